dmem_responder: RTL and testbench
=================================

# dmem_responder

Single-port data-memory responder serving the RV64 core's load/store requests over a valid/ready request/response handshake. Backed by an internal byte-maskable doubleword SRAM mapped at a fixed base address, with programmable access latency and one outstanding request. Sits between the core's memory port and the simulation memory model.

## Interface
- `BASE`, 64'h0000_0000_8000_0000, byte address of word 0.
- `DEPTH`, 1024, number of 64-bit words; power of two.
- `LATENCY`, 2, wait cycles between acceptance and response; range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept.
- `req_addr`  in  64  byte address; bits [2:0] ignored.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_wdata`  in  64  store data, doubleword-aligned lanes.
- `req_wmask`  in  8  byte enables; bit i enables `req_wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  64  load data; 0 for stores and errors.
- `resp_err`  out  1  address out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, latch addr/wen/wdata/wmask, load counter with LATENCY-1, go to WAIT.
- WAIT: `req_ready`=0. Counter decrements each edge. On the edge where counter is 0, perform the access and go to RESP.
- Access: index = (addr - BASE) >> 3. In range iff addr >= BASE and index < DEPTH. In range + load: `resp_rdata` = mem[index]. In range + store: bytes with mask bit 1 are written, others kept; `resp_rdata`=0. Out of range: no write, `resp_rdata`=0, `resp_err`=1.
- A store with `req_wmask`=0 completes normally with no memory change.
- RESP: `resp_valid`=1, `resp_rdata`/`resp_err` held stable until `resp_ready`=1 at an edge, then go to IDLE.
- `req_*` inputs are ignored outside IDLE.
- Address arithmetic is 64-bit unsigned; addr < BASE never wraps into range.

## Timing
- Reset values: state IDLE, `req_ready`=0 during the reset cycle and 1 on the first cycle after reset deasserts, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- Reset mid-operation (WAIT or RESP) aborts: a store still in WAIT is not committed; a store already in RESP stays committed. Memory contents are never cleared by reset.
- Acceptance at edge E0 puts `resp_valid` high after edge E0+LATENCY.
- Response consumed at edge E1 puts `req_ready` high after E1. No request is accepted in the same cycle a response is consumed.
- Minimum request-to-request spacing: LATENCY+2 cycles when `resp_ready` is held high.
- `req_ready` and `resp_valid` are never both 1.
- Outputs are registered or pure state decode; no combinational path from inputs to outputs.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the default BASE constant;
  - a `dmem_req_t` struct {addr, wen, wdata, wmask} used for the request latch.
- Sub-module `sram_1rw_be`: DEPTH x 64 array, one read/write port with byte enables, synchronous write, combinational read. Instantiated once; the responder drives it only on the access edge.

## Test plan
- Reset, then load from 0x8000_0000 with LATENCY=2 -> `resp_valid` rises exactly 2 edges after acceptance, `resp_rdata`=0 (preloaded zero), `resp_err`=0.
- Store 0x1122_3344_5566_7788 to 0x8000_0010 with mask 0xFF, then store 0xAAAA_AAAA_AAAA_AAAA to the same address with mask 0x0F, then load it -> load returns 0x1122_3344_AAAA_AAAA.
- Load 0x7FFF_FFF8 and load 0x8000_0000+8*DEPTH -> both give `resp_err`=1, `resp_rdata`=0. A store to 0x8000_2000 (DEPTH=1024) leaves memory unchanged.
- Hold `resp_ready`=0 for 5 cycles in RESP -> `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0. Raising `resp_ready` -> `req_ready` rises the next cycle.
- Assert `rst` one cycle after accepting a store to 0x8000_0020 (LATENCY=3), then load the same address -> old contents returned and `resp_valid`=0 during reset.
- Load from 0x8000_0015 -> returns the word at 0x8000_0010 (bits [2:0] ignored).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] DEFAULT_BASE = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } dmem_req_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port doubleword RAM with per-byte write enables and combinational read.
module sram_1rw_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wmask,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && wen) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one outstanding request, fixed latency, backed by a
// byte-maskable doubleword SRAM mapped at BASE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [63:0] BASE    = DEFAULT_BASE,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [60:0] DEPTH_W = 61'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  count;
  dmem_req_t   req_q;
  logic [60:0] word_off;
  logic        in_range;
  logic        access;
  logic [63:0] sram_rdata;

  // Word offset in 64-bit arithmetic; addresses below BASE are rejected
  // explicitly so the wrapped subtraction can never land in range.
  assign word_off = req_q.addr[63:3] - BASE[63:3];
  assign in_range = (req_q.addr >= BASE) && (word_off < DEPTH_W);
  assign access   = (state == WAIT) && (count == 4'd0) && !rst;

  sram_1rw_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (access && in_range),
    .wen   (req_q.wen),
    .addr  (word_off[AW-1:0]),
    .wdata (req_q.wdata),
    .wmask (req_q.wmask),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{addr: req_addr, wen: req_wen,
                           wdata: req_wdata, wmask: req_wmask};
            count     <= CNT_INIT;
            state     <= WAIT;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !req_q.wen) ? sram_rdata : 64'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed table, stall/reset sequences and random traffic
// against a flat array model of the memory.
module tb_dmem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [63:0] req_addr   [2];
  logic        req_wen    [2];
  logic [63:0] req_wdata  [2];
  logic [7:0]  req_wmask  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];

  int errors = 0;
  int checks = 0;
  int lat_exp [2] = '{2, 3};

  logic [63:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wen(req_wen[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wen(req_wen[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory is a flat array of doublewords starting at BASE.
  task automatic model_access(input logic [63:0] a, input logic w, input logic [63:0] d,
                              input logic [7:0] m, output logic [63:0] rd, output logic er);
    logic [63:0] idx;
    rd = 64'd0;
    er = 1'b0;
    if (a < BASE || (a - BASE) / 8 >= 64'(DEPTH)) begin
      er = 1'b1;
    end else begin
      idx = (a - BASE) / 8;
      if (w) begin
        for (int i = 0; i < 8; i++)
          if (m[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        rd = model[idx];
      end
    end
  endtask

  // Issue one request and wait for its response; consumes it if resp_ready is high.
  task automatic do_req(input int u, input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] m, output logic [63:0] rd, output logic er);
    int b;
    int lat;
    rd = 64'd0;
    er = 1'b0;
    @(negedge clk);
    b = 0;
    while (!req_ready[u] && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready[u]) begin
      chk("req_ready_timeout", 64'(req_ready[u]), 64'd1);
      return;
    end
    req_valid[u] = 1'b1;
    req_addr[u]  = a;
    req_wen[u]   = w;
    req_wdata[u] = d;
    req_wmask[u] = m;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    req_addr[u]  = $urandom;
    chk("ready_low_after_accept", 64'(req_ready[u]), 64'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid[u] && lat < 40);
    chk("latency", 64'(lat), 64'(lat_exp[u]));
    chk("ready_valid_exclusive", 64'(req_ready[u]), 64'd0);
    rd = resp_rdata[u];
    er = resp_err[u];
    if (resp_ready[u]) begin
      @(posedge clk);
      #1;
      chk("handoff_req_ready", 64'(req_ready[u]), 64'd1);
      chk("handoff_resp_valid", 64'(resp_valid[u]), 64'd0);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl [$];
    logic [63:0] rd, mrd, hold_rd;
    logic        er, mer, hold_er;
    logic [63:0] a;
    logic        w;
    logic [7:0]  m;
    logic [63:0] d;

    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_addr[u] = 64'd0; req_wen[u] = 1'b0;
      req_wdata[u] = 64'd0; req_wmask[u] = 8'd0; resp_ready[u] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready[0]), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("reset_resp_rdata", resp_rdata[0], 64'd0);
    chk("reset_resp_err", 64'(resp_err[0]), 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_req_ready", 64'(req_ready[0]), 64'd1);

    tbl = '{
      '{64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0},
      '{64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0},
      '{64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, 1'b0},
      '{64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0},
      '{64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1},
      '{64'h8000_2000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1},
      '{64'h8000_2000, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 1'b1},
      '{64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1},
      '{64'h8000_1FF8, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0},
      '{64'h8000_1FF8, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h81, 64'h0, 1'b0},
      '{64'h8000_1FF8, 1'b0, 64'h0, 8'h00, 64'hDE00_0000_0000_000D, 1'b0},
      '{64'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 1'b0},
      '{64'h8000_0015, 1'b0, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0},
      '{64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0}
    };
    foreach (tbl[i]) begin
      do_req(0, tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].wmask, rd, er);
      model_access(tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].wmask, mrd, mer);
      $display("vec %0d addr=%h wen=%0d mask=%h -> rdata=%h err=%0d", i, tbl[i].addr,
               tbl[i].wen, tbl[i].wmask, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
    end

    // Response held off by the core: outputs must stay frozen.
    resp_ready[0] = 1'b0;
    do_req(0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, hold_rd, hold_er);
    chk("stall_first_rdata", hold_rd, 64'h1122_3344_AAAA_AAAA);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(resp_valid[0]), 64'd1);
      chk("stall_rdata", resp_rdata[0], hold_rd);
      chk("stall_err", 64'(resp_err[0]), 64'(hold_er));
      chk("stall_req_ready", 64'(req_ready[0]), 64'd0);
    end
    @(negedge clk);
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("release_req_ready", 64'(req_ready[0]), 64'd1);
    chk("release_resp_valid", 64'(resp_valid[0]), 64'd0);
    $display("stall test rdata=%h err=%0d", hold_rd, hold_er);

    // Randomized traffic against the array model, clustered to force reuse.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
        1:       a = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 63));
        2:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        3, 4:    a = BASE + 64'(8 * $urandom_range(DEPTH - 4, DEPTH - 1)) + 64'($urandom_range(0, 7));
        default: a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      endcase
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      m = 8'($urandom);
      do_req(0, a, w, d, m, rd, er);
      model_access(a, w, d, m, mrd, mer);
      $display("rand %0d addr=%h wen=%0d mask=%h -> rdata=%h err=%0d", n, a, w, m, rd, er);
      chk("rand_rdata", rd, mrd);
      chk("rand_err", 64'(er), 64'(mer));
    end

    // LATENCY=3 instance: reset during WAIT aborts the store.
    do_req(1, 64'h8000_0020, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er);
    @(negedge clk);
    while (!req_ready[1]) @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 64'h8000_0020;
    req_wen[1]   = 1'b1;
    req_wdata[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_wmask[1] = 8'hFF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_reset_resp_valid", 64'(resp_valid[1]), 64'd0);
    chk("abort_reset_req_ready", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    do_req(1, 64'h8000_0020, 1'b0, 64'h0, 8'h00, rd, er);
    $display("abort test rdata=%h err=%0d", rd, er);
    chk("abort_old_contents", rd, 64'h0123_4567_89AB_CDEF);

    // A store already responding stays committed across reset.
    resp_ready[1] = 1'b0;
    do_req(1, 64'h8000_0028, 1'b1, 64'hCAFE_0000_BEEF_1111, 8'hFF, rd, er);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_reset_resp_valid", 64'(resp_valid[1]), 64'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    resp_ready[1] = 1'b1;
    do_req(1, 64'h8000_0028, 1'b0, 64'h0, 8'h00, rd, er);
    $display("committed test rdata=%h err=%0d", rd, er);
    chk("resp_reset_committed", rd, 64'hCAFE_0000_BEEF_1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
